// File: rtl/div_pkg.sv
// Shared constants and types for the sequential signed divider.
package div_pkg;

    localparam int NUMBIT = 10;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

endpackage

// File: rtl/div_step.sv
// One radix-2 non-restoring division iteration on magnitudes.
module div_step
    import div_pkg::*;
#(
    parameter int numbit = NUMBIT
) (
    input  logic [numbit:0]   part_rem,
    input  logic [numbit-1:0] quo_in,
    input  logic [numbit-1:0] div_mag,
    output logic [numbit:0]   rem_next,
    output logic [numbit-1:0] quo_next
);

    logic [numbit:0] shifted;

    // |part_rem| < div_mag, so the doubled value still fits in numbit+1 signed bits
    assign shifted  = {part_rem[numbit-1:0], quo_in[numbit-1]};
    assign rem_next = part_rem[numbit] ? (shifted + {1'b0, div_mag})
                                       : (shifted - {1'b0, div_mag});
    assign quo_next = {quo_in[numbit-2:0], ~rem_next[numbit]};

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle signed divider: truncating quotient, remainder follows dividend sign.
module seq_divider
    import div_pkg::*;
#(
    parameter int numbit = NUMBIT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [numbit-1:0] dividend,
    input  logic [numbit-1:0] divisor,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [numbit-1:0] quotient,
    output logic [numbit-1:0] remainder,
    output logic              div_by_zero
);

    localparam int CNT_W = $clog2(numbit + 1);

    state_t            state;
    logic [CNT_W-1:0]  iter_cnt;
    logic [numbit:0]   part_rem;
    logic [numbit-1:0] quo_acc;
    logic [numbit-1:0] div_mag;
    logic              sign_dividend;
    logic              sign_divisor;
    logic              zero_div;

    logic [numbit:0]   step_rem;
    logic [numbit-1:0] step_quo;
    logic [numbit-1:0] dividend_mag;
    logic [numbit-1:0] divisor_mag;
    logic [numbit-1:0] rem_mag;

    div_step #(.numbit(numbit)) u_step (
        .part_rem (part_rem),
        .quo_in   (quo_acc),
        .div_mag  (div_mag),
        .rem_next (step_rem),
        .quo_next (step_quo)
    );

    // Magnitude of the most negative value wraps to itself, which is correct as unsigned
    assign dividend_mag = dividend[numbit-1] ? -dividend : dividend;
    assign divisor_mag  = divisor[numbit-1]  ? -divisor  : divisor;
    assign rem_mag      = part_rem[numbit] ? (part_rem[numbit-1:0] + div_mag)
                                           : part_rem[numbit-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            in_ready      <= 1'b1;
            out_valid     <= 1'b0;
            iter_cnt      <= '0;
            part_rem      <= '0;
            quo_acc       <= '0;
            div_mag       <= '0;
            sign_dividend <= 1'b0;
            sign_divisor  <= 1'b0;
            zero_div      <= 1'b0;
            quotient      <= '0;
            remainder     <= '0;
            div_by_zero   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        part_rem      <= '0;
                        quo_acc       <= dividend_mag;
                        div_mag       <= divisor_mag;
                        sign_dividend <= dividend[numbit-1];
                        sign_divisor  <= divisor[numbit-1];
                        zero_div      <= (divisor == '0);
                        iter_cnt      <= '0;
                        in_ready      <= 1'b0;
                        state         <= CALC;
                    end
                end
                CALC: begin
                    // A zero divisor skips the iterations; quo_acc still holds |dividend|
                    if (zero_div) begin
                        quotient    <= '1;
                        remainder   <= sign_dividend ? -quo_acc : quo_acc;
                        div_by_zero <= 1'b1;
                        out_valid   <= 1'b1;
                        state       <= DONE;
                    end else if (iter_cnt == CNT_W'(numbit)) begin
                        quotient    <= (sign_dividend ^ sign_divisor) ? -quo_acc : quo_acc;
                        remainder   <= sign_dividend ? -rem_mag : rem_mag;
                        div_by_zero <= 1'b0;
                        out_valid   <= 1'b1;
                        state       <= DONE;
                    end else begin
                        part_rem <= step_rem;
                        quo_acc  <= step_quo;
                        iter_cnt <= iter_cnt + CNT_W'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule
